// File: rtl/key_beep_pkg.sv
// Shared types and cycle-count helpers for the key-press beep player.
package key_beep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2
    } state_e;

    function automatic int unsigned ms_to_cycles(int unsigned clk_freq, int unsigned ms);
        return (clk_freq / 1000) * ms;
    endfunction

    function automatic int unsigned half_period_cycles(int unsigned clk_freq, int unsigned tone_hz);
        return clk_freq / (2 * tone_hz);
    endfunction

endpackage

// File: rtl/beep_tone_gen.sv
// Enable-gated square-wave divider: starts high on the cycle en rises, held low while en=0.
module beep_tone_gen #(
    parameter int unsigned HALF_CYC = 2
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic en,
    output logic tone
);

    localparam int CNT_W = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tone_q, tone_d;
    logic             en_q;

    always_comb begin
        cnt_d  = cnt_q;
        tone_d = tone_q;
        if (!en) begin
            cnt_d  = '0;
            tone_d = 1'b0;
        end else if (!en_q) begin
            cnt_d  = '0;
            tone_d = 1'b1;
        end else if (cnt_q == CNT_W'(HALF_CYC - 1)) begin
            cnt_d  = '0;
            tone_d = ~tone_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tone_q <= 1'b0;
            en_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tone_q <= tone_d;
            en_q   <= en;
        end
    end

    assign tone = tone_q;

endmodule

// File: rtl/key_beep_player.sv
// Turns debounced key presses into fixed-length buzzer bursts separated by a silent gap,
// queueing presses that arrive while a burst is in progress.
//   state | meaning
//   IDLE  | nothing playing, queue empty
//   TONE  | square wave on the buzzer for BEEP_CYC cycles
//   GAP   | silence for GAP_CYC cycles before the next burst or IDLE
module key_beep_player
    import key_beep_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned TONE_HZ   = 2_000,
    parameter int unsigned BEEP_MS   = 100,
    parameter int unsigned GAP_MS    = 50,
    parameter int          PENDING_W = 3
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 key_flag,
    input  logic                 key_value,
    output logic                 beep,
    output logic                 busy,
    output logic [PENDING_W-1:0] pending,
    output logic                 overflow
);

    localparam int unsigned HALF_CYC = half_period_cycles(CLK_FREQ, TONE_HZ);
    localparam int unsigned BEEP_CYC = ms_to_cycles(CLK_FREQ, BEEP_MS);
    localparam int unsigned GAP_CYC  = ms_to_cycles(CLK_FREQ, GAP_MS);
    localparam int unsigned MAX_CYC  = (BEEP_CYC > GAP_CYC) ? BEEP_CYC : GAP_CYC;
    localparam int          DUR_W    = $clog2(MAX_CYC + 1);
    localparam logic [PENDING_W-1:0] PEND_MAX = '1;

    if (HALF_CYC < 1 || BEEP_CYC < 1 || GAP_CYC < 1) begin : g_bad_params
        $error("key_beep_player: derived cycle counts must be at least 1");
    end

    state_e               state_q, state_d;
    logic [DUR_W-1:0]     dur_q, dur_d;
    logic [PENDING_W-1:0] pending_q, pending_d;
    logic                 overflow_q, overflow_d;
    logic                 press;
    logic                 start;
    logic                 have_work;

    assign press     = key_flag && !key_value;
    assign have_work = press || (pending_q != '0);

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (have_work) begin
                    state_d = TONE;
                    start   = 1'b1;
                end
            end
            TONE: begin
                if (dur_q == DUR_W'(BEEP_CYC - 1)) state_d = GAP;
            end
            GAP: begin
                if (dur_q == DUR_W'(GAP_CYC - 1)) begin
                    if (have_work) begin
                        state_d = TONE;
                        start   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Duration counter idles at zero and restarts on every state change.
    always_comb begin
        dur_d = dur_q + 1'b1;
        if (state_d != state_q || state_q == IDLE) dur_d = '0;
    end

    // A start that coincides with a press consumes that press, so the queue is untouched.
    always_comb begin
        pending_d  = pending_q;
        overflow_d = 1'b0;
        if (start) begin
            if (!press) pending_d = pending_q - 1'b1;
        end else if (press) begin
            if (pending_q == PEND_MAX) overflow_d = 1'b1;
            else                       pending_d  = pending_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q    <= IDLE;
            dur_q      <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dur_q      <= dur_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    // Driven from next state so the first high half-period lines up with TONE entry.
    beep_tone_gen #(
        .HALF_CYC(HALF_CYC)
    ) u_tone (
        .sys_clk(sys_clk),
        .rst    (rst),
        .en     (state_d == TONE),
        .tone   (beep)
    );

    assign busy     = (state_q != IDLE);
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule
